data_ram_bank: RTL and testbench
================================

Name: data_ram_bank

Overview:
- Parametrised, byte-lane-enabled, single-port synchronous data memory for the MEM stage; supersedes the fixed 32-bit data RAM.
- Adds a req/ready/rvalid handshake, registered 1-cycle read latency, post-reset sequential clear of all words, and out-of-range address detection.
- Sits between the MEM-stage load/store unit and on-chip data storage.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8; BYTES = DATA_W/8, OFS = log2(BYTES).
- DEPTH, 1024, number of words; power of 2; IDX = log2(DEPTH).
- ADDR_W, 32, byte-address width; ADDR_W >= IDX+OFS.
- INIT_CLEAR, 1, 1 = zero every word after reset; 0 = skip clear, ready straight after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  chip enable; 0 = block ignores req.
- req  in  1  access request.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  ADDR_W  byte address; word index = addr[IDX+OFS-1:OFS]; low OFS bits ignored.
- sel  in  BYTES  byte-lane enables for writes; sel[BYTES-1] = data_i MSB byte = lowest byte address (big-endian).
- data_i  in  DATA_W  write data.
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  one-cycle pulse; data_o holds a read result.
- data_o  out  DATA_W  read data; holds its value until the next accepted read.
- addr_err  out  1  one-cycle pulse; the accepted request had addr bits above IDX+OFS-1 nonzero.
- init_done  out  1  high once the clear sequence is complete.

Behaviour:
- Reset: ready=0, rvalid=0, data_o=0, addr_err=0, init_done=0, clear counter=0, state=INIT (or RUN if INIT_CLEAR=0).
- FSM INIT:
  - Each cycle write 0 to all lanes of word[counter], then counter+1.
  - On the write of word DEPTH-1, go to RUN; init_done=1 from the next cycle.
  - ready=0 throughout; requests are ignored.
  - Clear takes exactly DEPTH cycles.
- FSM RUN:
  - ready = ce.
  - Accept = req && ready.
  - RUN has no exit except rst.
- Accepted write:
  - Lanes with sel[i]=1 are updated at that edge; other lanes are unchanged.
  - sel=0 is a legal no-op write.
  - No rvalid is generated.
- Accepted read:
  - rvalid=1 and data_o=word on the following cycle.
  - Back-to-back reads: one accept per cycle, results in order.
  - A read accepted the cycle after a write to the same word returns the written bytes merged with the unselected old bytes.
- Out-of-range accept (upper bits nonzero):
  - addr_err=1 on the next cycle.
  - Write: memory is not modified.
  - Read: rvalid=1 with data_o=0.
- ce=0 in RUN: ready=0; rvalid/addr_err of an already-accepted read still appear on the next cycle.
- rst in any state, including mid-INIT or with a read outstanding:
  - The outstanding response is dropped (rvalid=0 next cycle).
  - FSM restarts INIT from word 0; no partial write occurs on the rst cycle.
- Outputs are registered; there is no combinational path from req to rvalid or data_o.

Optional Feature:
- Macro: DATA_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, written with the byte; INIT clears data and parity to 0.
  - Output perr (1 bit) pulses with rvalid when any read lane's parity mismatches.
  - Bench-only input inj_perr (1 bit): when high on an accepted write, it inverts the stored parity of the selected lanes.
- Undefined: no parity storage; perr and inj_perr ports absent; timing unchanged.

Test Plan:
- INIT: DEPTH=16, rst for 1 cycle -> ready=0 for 16 cycles, then ready=1 and init_done=1; reading all 16 words returns 0x00000000.
- Byte enables: write 0xAABBCCDD to addr 0x8 with sel=4'b1111, then write 0x11223344 to addr 0x8 with sel=4'b0101 -> read of 0x8 gives rvalid 1 cycle after accept with data_o=0xAA22CC44.
- Throughput and ordering: reads of words 1, 2, 3 on consecutive cycles -> three consecutive rvalid pulses, data in order; data_o holds word 3's value afterwards.
- Out of range: DEPTH=1024, write to addr 0x1000 -> addr_err pulse and word 0 unchanged; read of 0x1000 -> rvalid=1, data_o=0, addr_err=1.
- Mid-operation reset:
  - rst asserted on the cycle after a read accept -> no rvalid.
  - rst asserted at clear counter=5 -> clear restarts at word 0, and ready rises DEPTH cycles after rst deasserts.
- DATA_RAM_PARITY_EN: write with inj_perr=1, sel=4'b0010 -> a subsequent read gives perr=1 with rvalid; rewriting that word normally -> perr=0.

Source files
------------

// File: rtl/data_ram_bank_if.sv
// Request/response bundle between the MEM-stage load/store unit and data_ram_bank.
// Parity signals exist only when DATA_RAM_PARITY_EN is defined.
interface data_ram_bank_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic              ce;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BYTES-1:0]  sel;
  logic [DATA_W-1:0] data_i;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] data_o;
  logic              addr_err;
  logic              init_done;
`ifdef DATA_RAM_PARITY_EN
  logic              perr;
  logic              inj_perr;
`endif

  modport master (
    output ce, req, we, addr, sel, data_i,
`ifdef DATA_RAM_PARITY_EN
    output inj_perr,
    input  perr,
`endif
    input  ready, rvalid, data_o, addr_err, init_done
  );

  modport slave (
    input  ce, req, we, addr, sel, data_i,
`ifdef DATA_RAM_PARITY_EN
    input  inj_perr,
    output perr,
`endif
    output ready, rvalid, data_o, addr_err, init_done
  );
endinterface

// File: rtl/data_ram_bank.sv
// Byte-lane single-port data RAM with post-reset clear, 1-cycle registered reads
// and out-of-range detection. Optional per-lane even parity via DATA_RAM_PARITY_EN.
module data_ram_bank #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_ram_bank_if.slave bus
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFS   = $clog2(BYTES);
  localparam int unsigned IDX   = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX-1:0]    clr_cnt;
  logic [IDX-1:0]    idx;
  logic              in_range;
  logic              ready;
  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic              last_clear;
  logic              rvalid_q;
  logic              addr_err_q;
  logic              init_done_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  assign idx = bus.addr[IDX+OFS-1:OFS];

  generate
    if (ADDR_W > IDX + OFS) begin : g_hi
      assign in_range = (bus.addr[ADDR_W-1:IDX+OFS] == '0);
    end else begin : g_no_hi
      assign in_range = 1'b1;
    end
    if (OFS > 0) begin : g_ofs
      logic unused_ofs;
      assign unused_ofs = ^bus.addr[OFS-1:0];
    end
  endgenerate

  assign last_clear = (clr_cnt == IDX'(DEPTH - 1));
  assign accept     = bus.req && ready;
  assign wr_en      = accept && bus.we && in_range;
  assign rd_en      = accept && !bus.we;

  always_ff @(posedge clk) begin
    if (rst) state <= (INIT_CLEAR != 0) ? INIT : RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (last_clear) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    if (state == RUN) ready = bus.ce;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt     <= '0;
      init_done_q <= (INIT_CLEAR == 0);
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (last_clear) init_done_q <= 1'b1;
    end
  end

  // Memory carries no reset; rst only blocks writes so the reset cycle never half-writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_cnt] <= '0;
      end else if (wr_en) begin
        for (int unsigned i = 0; i < BYTES; i++)
          if (bus.sel[i]) mem[idx][8*i +: 8] <= bus.data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
      data_q     <= '0;
    end else begin
      rvalid_q   <= rd_en;
      addr_err_q <= accept && !in_range;
      if (rd_en) data_q <= in_range ? mem[idx] : '0;
    end
  end

`ifdef DATA_RAM_PARITY_EN
  logic [BYTES-1:0] par [DEPTH];
  logic [BYTES-1:0] rd_par;
  logic             perr_q;

  always_comb begin
    rd_par = '0;
    for (int unsigned i = 0; i < BYTES; i++) rd_par[i] = ^mem[idx][8*i +: 8];
  end

  // Stored bit makes each lane's byte+parity XOR to zero; inj_perr flips it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        par[clr_cnt] <= '0;
      end else if (wr_en) begin
        for (int unsigned i = 0; i < BYTES; i++)
          if (bus.sel[i]) par[idx][i] <= (^bus.data_i[8*i +: 8]) ^ bus.inj_perr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= rd_en && in_range && ((rd_par ^ par[idx]) != '0);
  end

  assign bus.perr = perr_q;
`endif

  assign bus.ready     = ready;
  assign bus.rvalid    = rvalid_q;
  assign bus.data_o    = data_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_data_ram_bank.sv
// Directed self-checking bench for data_ram_bank (DEPTH=16, 32-bit words).
// Parity checks are compiled in when DATA_RAM_PARITY_EN is defined.
module tb_data_ram_bank;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   n;

  data_ram_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_ram_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_CLEAR(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d; bus.sel = s;
    step();
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
    step();
    bus.req = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check(tag, 64'(n), 64'(DEPTH));
  endtask

  initial begin
    bus.ce = 1'b1; bus.req = 1'b0; bus.we = 1'b0;
    bus.addr = '0; bus.sel = '0; bus.data_i = '0;
`ifdef DATA_RAM_PARITY_EN
    bus.inj_perr = 1'b0;
`endif
    // Reset state and clear duration
    rst = 1'b1;
    step();
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_data", 64'(bus.data_o), 64'd0);
    check("rst_addr_err", 64'(bus.addr_err), 64'd0);
    check("rst_init_done", 64'(bus.init_done), 64'd0);
    rst = 1'b0;
    wait_ready("init_cycles");
    check("init_done", 64'(bus.init_done), 64'd1);

    for (int w = 0; w < 16; w++) begin
      rd(32'(w * 4));
      check("clr_rvalid", 64'(bus.rvalid), 64'd1);
      check("clr_data", 64'(bus.data_o), 64'd0);
    end

    // Byte enables, with the read immediately after the partial write
    wr(32'h8, 32'hAABBCCDD, 4'b1111);
    check("wr_no_rvalid", 64'(bus.rvalid), 64'd0);
    wr(32'h8, 32'h11223344, 4'b0101);
    rd(32'h8);
    check("be_rvalid", 64'(bus.rvalid), 64'd1);
    check("be_data", 64'(bus.data_o), 64'hAA22CC44);
    wr(32'h8, 32'h55555555, 4'b0000);
    rd(32'h8);
    check("sel0_data", 64'(bus.data_o), 64'hAA22CC44);

    // Back-to-back reads and data_o hold
    wr(32'h4, 32'h11110001, 4'b1111);
    wr(32'h8, 32'h22220002, 4'b1111);
    wr(32'hC, 32'h33330003, 4'b1111);
    bus.req = 1'b1; bus.we = 1'b0;
    bus.addr = 32'h4; step();
    check("b2b_v1", 64'(bus.rvalid), 64'd1);
    check("b2b_d1", 64'(bus.data_o), 64'h11110001);
    bus.addr = 32'h8; step();
    check("b2b_v2", 64'(bus.rvalid), 64'd1);
    check("b2b_d2", 64'(bus.data_o), 64'h22220002);
    bus.addr = 32'hC; step();
    check("b2b_v3", 64'(bus.rvalid), 64'd1);
    check("b2b_d3", 64'(bus.data_o), 64'h33330003);
    bus.req = 1'b0; step();
    check("hold_rvalid", 64'(bus.rvalid), 64'd0);
    check("hold_data", 64'(bus.data_o), 64'h33330003);
    rd(32'hB);
    check("low_bits_ignored", 64'(bus.data_o), 64'h22220002);

    // Out-of-range accesses
    wr(32'h1000, 32'hDEADBEEF, 4'b1111);
    check("oor_wr_err", 64'(bus.addr_err), 64'd1);
    check("oor_wr_rvalid", 64'(bus.rvalid), 64'd0);
    step();
    check("oor_err_pulse", 64'(bus.addr_err), 64'd0);
    rd(32'h0);
    check("oor_word0", 64'(bus.data_o), 64'd0);
    rd(32'h1000);
    check("oor_rd_rvalid", 64'(bus.rvalid), 64'd1);
    check("oor_rd_data", 64'(bus.data_o), 64'd0);
    check("oor_rd_err", 64'(bus.addr_err), 64'd1);
    rd(32'h3C);
    check("top_word_err", 64'(bus.addr_err), 64'd0);
    check("top_word_rvalid", 64'(bus.rvalid), 64'd1);
    rd(32'h40);
    check("first_oor_err", 64'(bus.addr_err), 64'd1);

    // Chip enable low blocks acceptance
    bus.ce = 1'b0;
    #1;
    check("ce0_ready", 64'(bus.ready), 64'd0);
    wr(32'h4, 32'hFFFFFFFF, 4'b1111);
    rd(32'h4);
    check("ce0_no_rvalid", 64'(bus.rvalid), 64'd0);
    bus.ce = 1'b1;
    rd(32'h4);
    check("ce0_no_write", 64'(bus.data_o), 64'h11110001);

`ifdef DATA_RAM_PARITY_EN
    bus.inj_perr = 1'b1;
    wr(32'h14, 32'h12345678, 4'b0010);
    bus.inj_perr = 1'b0;
    rd(32'h14);
    check("perr_rvalid", 64'(bus.rvalid), 64'd1);
    check("perr_set", 64'(bus.perr), 64'd1);
    wr(32'h14, 32'h12345678, 4'b1111);
    rd(32'h14);
    check("perr_clear", 64'(bus.perr), 64'd0);
`endif

    // Reset with a read just accepted, then reset in the middle of the clear
    wr(32'h0, 32'hCAFEF00D, 4'b1111);
    wr(32'h28, 32'h0BADBEEF, 4'b1111);
    rd(32'h28);
    check("pre_rst_rvalid", 64'(bus.rvalid), 64'd1);
    rst = 1'b1; bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h28;
    step();
    bus.req = 1'b0;
    check("rst_drops_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_ready_low", 64'(bus.ready), 64'd0);
    rst = 1'b0;
    repeat (5) step();
    check("mid_init_ready", 64'(bus.ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready("reinit_cycles");
    rd(32'h0);
    check("reinit_word0", 64'(bus.data_o), 64'd0);
    rd(32'h28);
    check("reinit_word10", 64'(bus.data_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
